// File: rtl/fp_adder_if.sv
// Operand/result bus for the binary32 adder: operands in, registered result out.
interface fp_adder_if;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic [31:0] Sum;
  logic        overFlow;

  modport master (output in_valid, A, B, input out_valid, Sum, overFlow);
  modport slave  (input in_valid, A, B, output out_valid, Sum, overFlow);
endinterface

// File: rtl/fp_adder.sv
// Binary32 adder, round-to-nearest-even, subnormals flushed, registered result.
// FP_ADDER_IN_REG_EN adds an input register stage (latency 1 -> 2).
module fp_adder (
  input  logic           clk,
  input  logic           rst,
  fp_adder_if.slave      bus
);

  logic [31:0] a, b;
  logic        v;

`ifdef FP_ADDER_IN_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      a <= '0;
      b <= '0;
    end else begin
      v <= bus.in_valid;
      a <= bus.A;
      b <= bus.B;
    end
  end
`else
  assign v = bus.in_valid;
  assign a = bus.A;
  assign b = bus.B;
`endif

  function automatic logic [4:0] lzc27(input logic [26:0] x);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 27; i++)
      if (x[i]) n = 5'(26 - i);
    return n;
  endfunction

  logic              sa, sb, sl, swap;
  logic [7:0]        ea, eb, el, es, d;
  logic [22:0]       fa, fb;
  logic [23:0]       ml, ms;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [49:0]       shifted;
  logic [26:0]       bigx, sm, diff, r;
  logic [27:0]       sum28;
  logic [4:0]        lz;
  logic              cancel, rup;
  logic [24:0]       m25;
  logic [22:0]       frac;
  logic signed [9:0] e;
  logic [31:0]       res;
  logic              ovf;

  always_comb begin
    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31]; eb = b[30:23]; fb = b[22:0];
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);

    // Larger magnitude goes first so subtraction never goes negative
    swap = {ea, fa} < {eb, fb};
    sl = swap ? sb : sa;
    el = swap ? eb : ea;
    es = swap ? ea : eb;
    ml = {1'b1, swap ? fb : fa};
    ms = {1'b1, swap ? fa : fb};
    d  = el - es;

    // Aligned small operand: 24-bit significand, guard, round, sticky
    shifted = {ms, 26'd0} >> d;
    if (d >= 8'd26) sm = 27'd1;
    else            sm = {shifted[49:24], |shifted[23:0]};
    bigx = {ml, 3'b000};

    sum28  = '0;
    diff   = '0;
    lz     = '0;
    cancel = 1'b0;
    if (sa == sb) begin
      sum28 = {1'b0, bigx} + {1'b0, sm};
      if (sum28[27]) begin
        r = {sum28[27:2], |sum28[1:0]};
        e = $signed({2'b00, el}) + 10'sd1;
      end else begin
        r = sum28[26:0];
        e = $signed({2'b00, el});
      end
    end else begin
      diff   = bigx - sm;
      cancel = (diff == 27'd0);
      lz     = lzc27(diff);
      r      = diff << lz;
      e      = $signed({2'b00, el}) - $signed({5'd0, lz});
    end

    rup = r[2] & (r[1] | r[0] | r[3]);
    m25 = {1'b0, r[26:3]} + {24'd0, rup};
    if (m25[24]) begin
      frac = m25[23:1];
      e    = e + 10'sd1;
    end else begin
      frac = m25[22:0];
    end

    ovf = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      res = 32'h7FC00000;
    end else if (a_inf) begin
      res = a;
      ovf = 1'b1;
    end else if (b_inf) begin
      res = b;
      ovf = 1'b1;
    end else if (a_zero && b_zero) begin
      res = {sa & sb, 31'd0};
    end else if (a_zero) begin
      res = b;
    end else if (b_zero) begin
      res = a;
    end else if (cancel) begin
      res = 32'h00000000;
    end else if (e >= 10'sd255) begin
      res = {sl, 8'hFF, 23'd0};
      ovf = 1'b1;
    end else if (e <= 10'sd0) begin
      res = {sl, 31'd0};
    end else begin
      res = {sl, e[7:0], frac};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.Sum       <= '0;
      bus.overFlow  <= 1'b0;
    end else begin
      bus.out_valid <= v;
      if (v) begin
        bus.Sum      <= res;
        bus.overFlow <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_fp_adder.sv
// Directed-vector bench for fp_adder: table of hand-computed sums plus
// back-to-back throughput and mid-stream reset sequences.
module tb_fp_adder;

`ifdef FP_ADDER_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NV = 19;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        ov;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[NV];

  fp_adder_if bus();
  fp_adder dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    tbl[0]  = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1};
    tbl[1]  = '{32'hFF800000, 32'hBF800000, 32'hFF800000, 1'b1};
    tbl[2]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0};
    tbl[3]  = '{32'h3FC00000, 32'hC0B00000, 32'hC0800000, 1'b0};
    tbl[4]  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0};
    tbl[5]  = '{32'h3FA00000, 32'h40200000, 32'h40700000, 1'b0};
    tbl[6]  = '{32'hBFA00000, 32'hC0200000, 32'hC0700000, 1'b0};
    tbl[7]  = '{32'h3F99999A, 32'h00000000, 32'h3F99999A, 1'b0};
    tbl[8]  = '{32'hBF99999A, 32'h00000000, 32'hBF99999A, 1'b0};
    tbl[9]  = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
    tbl[10] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1};
    tbl[11] = '{32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0};
    tbl[12] = '{32'h3F800000, 32'h33800001, 32'h3F800001, 1'b0};
    tbl[13] = '{32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0};
    tbl[14] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0};
    tbl[15] = '{32'h00000001, 32'h3F800000, 32'h3F800000, 1'b0};
    tbl[16] = '{32'h80800001, 32'h00800000, 32'h80000000, 1'b0};
    tbl[17] = '{32'h80000000, 32'h80000000, 32'h80000000, 1'b0};
    tbl[18] = '{32'h3F800000, 32'hFF800000, 32'hFF800000, 1'b1};

    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.A = 32'h3F800000;
    bus.B = 32'h3F800000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_sum", bus.Sum, 32'd0);
    chk("reset_overflow", {31'd0, bus.overFlow}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;

    // One operation at a time
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.A = tbl[i].a;
      bus.B = tbl[i].b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (LAT - 1) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("vec%0d_sum", i), bus.Sum, tbl[i].sum);
      chk($sformatf("vec%0d_ovf", i), {31'd0, bus.overFlow}, {31'd0, tbl[i].ov});
    end

    // Idle: valid drops, result holds
    repeat (LAT + 1) @(posedge clk);
    #1;
    chk("idle_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("idle_hold_sum", bus.Sum, tbl[NV-1].sum);
    chk("idle_hold_ovf", {31'd0, bus.overFlow}, {31'd0, tbl[NV-1].ov});

    // Back-to-back, one result per cycle at fixed latency
    for (int c = 0; c < NV + LAT; c++) begin
      @(negedge clk);
      if (c < NV) begin
        bus.in_valid = 1'b1;
        bus.A = tbl[c].a;
        bus.B = tbl[c].b;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (c - LAT + 1 >= 0 && c - LAT + 1 < NV) begin
        chk($sformatf("b2b%0d_valid", c - LAT + 1), {31'd0, bus.out_valid}, 32'd1);
        chk($sformatf("b2b%0d_sum", c - LAT + 1), bus.Sum, tbl[c - LAT + 1].sum);
        chk($sformatf("b2b%0d_ovf", c - LAT + 1), {31'd0, bus.overFlow}, {31'd0, tbl[c - LAT + 1].ov});
      end
    end

    // Reset mid-stream drops in-flight work
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = tbl[10].a;
    bus.B = tbl[10].b;
    @(negedge clk);
    rst = 1'b1;
    bus.A = tbl[5].a;
    bus.B = tbl[5].b;
    @(posedge clk);
    #1;
    chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_sum", bus.Sum, 32'd0);
    chk("midrst_ovf", {31'd0, bus.overFlow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    for (int k = 0; k < LAT + 1; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("postrst%0d_valid", k), {31'd0, bus.out_valid}, 32'd0);
      chk($sformatf("postrst%0d_sum", k), bus.Sum, 32'd0);
    end

    // Pipeline restarts cleanly after reset
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = tbl[3].a;
    bus.B = tbl[3].b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk("restart_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("restart_sum", bus.Sum, tbl[3].sum);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
